eb_arb: RTL



---
 rtl/eb_arb_if.sv | 27 ++
 rtl/eb_arb.sv | 84 ++++++++
 2 files changed

// File: rtl/eb_arb_if.sv
// Elastic valid/ready bundle between N producers, the round-robin merge and one consumer.
// The slave modport is the arbiter's view; the master modport is the view of the producers and the consumer.
interface eb_arb_if #(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter int SEL_WIDTH = $clog2(N)
);
    logic [N*WIDTH-1:0]   t_data;
    logic [N-1:0]         t_valid;
    logic [N-1:0]         t_last;
    logic [N-1:0]         t_ready;
    logic [WIDTH-1:0]     i_0_data;
    logic                 i_0_valid;
    logic                 i_0_last;
    logic [SEL_WIDTH-1:0] i_0_sel;
    logic                 i_0_ready;

    modport slave (
        input  t_data, t_valid, t_last, i_0_ready,
        output t_ready, i_0_data, i_0_valid, i_0_last, i_0_sel
    );

    modport master (
        output t_data, t_valid, t_last, i_0_ready,
        input  t_ready, i_0_data, i_0_valid, i_0_last, i_0_sel
    );
endinterface

// File: rtl/eb_arb.sv
// Zero-latency round-robin merge of N elastic channels onto one; grant held across stalls.
// EB_ARB_PKT_LOCK_EN: keep the grant on one channel until a beat with t_last transfers.
module eb_arb #(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter int SEL_WIDTH = $clog2(N)
) (
    input logic       clk,
    input logic       reset,
    eb_arb_if.slave   bus
);
    logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
    logic [SEL_WIDTH-1:0] hold_idx_q, hold_idx_d;
    logic                 hold_q, hold_d;
    logic [SEL_WIDTH-1:0] scan_sel, sel;
    logic                 xfer, stall;

    // base + off modulo N, valid for base < N and off < N
    function automatic logic [SEL_WIDTH-1:0] wrap_idx(input logic [SEL_WIDTH-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return SEL_WIDTH'(s);
    endfunction

    // Scan from the far end so the requester closest to ptr wins.
    always_comb begin
        scan_sel = ptr_q;
        for (int k = N - 1; k >= 0; k--) begin
            if (bus.t_valid[wrap_idx(ptr_q, k)]) scan_sel = wrap_idx(ptr_q, k);
        end
    end

    assign sel           = reset ? '0 : (hold_q ? hold_idx_q : scan_sel);
    assign bus.i_0_sel   = sel;
    assign bus.i_0_valid = !reset && bus.t_valid[sel];
    assign bus.i_0_data  = bus.t_data[sel*WIDTH +: WIDTH];
    assign bus.i_0_last  = bus.t_last[sel];

    for (genvar k = 0; k < N; k++) begin : g_rdy
        assign bus.t_ready[k] = !reset && bus.i_0_ready && (sel == SEL_WIDTH'(k));
    end

    assign xfer  = bus.i_0_valid && bus.i_0_ready;
    assign stall = bus.i_0_valid && !bus.i_0_ready;

    always_comb begin
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        hold_idx_d = hold_idx_q;
        if (stall) begin
            hold_d     = 1'b1;
            hold_idx_d = sel;
        end else if (xfer) begin
`ifdef EB_ARB_PKT_LOCK_EN
            if (!bus.i_0_last) begin
                hold_d     = 1'b1;
                hold_idx_d = sel;
            end else begin
                ptr_d  = wrap_idx(sel, 1);
                hold_d = 1'b0;
            end
`else
            ptr_d  = wrap_idx(sel, 1);
            hold_d = 1'b0;
`endif
        end else begin
            // Held requester dropped valid: let go rather than lock up.
            hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
        end
    end
endmodule
